// File: rtl/rx_medida_serial_pkg.sv
// ---------------------------------------------------------------------------
// rx_medida_serial_pkg
// Shared definitions for the measurement-stream receiver:
//   - default bit timing (50 MHz clock, 115200 baud)
//   - ASCII codes used by the frame format ("ddd#")
//   - frame-FSM state codes (also shown on db_estado)
//   - character-FSM state encodings
//   - helper that recognises an ASCII decimal digit
// ---------------------------------------------------------------------------
package rx_medida_serial_pkg;

    localparam int BIT_CLOCKS_PADRAO = 434;
    localparam int HALF_BIT_PADRAO   = 217;

    localparam logic [6:0] ASCII_HASH = 7'h23;
    localparam logic [6:0] ASCII_ZERO = 7'h30;

    typedef enum logic [3:0] {
        ESPERA_D2   = 4'h0,
        ESPERA_D1   = 4'h1,
        ESPERA_D0   = 4'h2,
        ESPERA_HASH = 4'h3,
        PUBLICA     = 4'h4
    } estado_quadro_t;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        RECEBE  = 3'd2,
        STOP    = 3'd3,
        ENTREGA = 3'd4
    } estado_char_t;

    // A digit is 0x30..0x39: upper three bits 011 and a low nibble of 0..9,
    // so the low nibble is directly the BCD value.
    function automatic logic eh_digito(input logic [6:0] c);
        return (c[6:4] == ASCII_ZERO[6:4]) && (c[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/rx_medida_serial_rx.sv
// ---------------------------------------------------------------------------
// rx_serial_7O1
// Asynchronous character receiver, 7 data bits LSB first, odd parity,
// one stop bit.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   entrada_serial in   raw RX line, idle high
//   dado           out  [6:0] last received character
//   dado_valido    out  1-cycle strobe: character with good parity and stop
//   erro           out  1-cycle strobe: parity error or stop bit = 0
// ---------------------------------------------------------------------------
module rx_serial_7O1
    import rx_medida_serial_pkg::*;
#(
    parameter int BIT_CLOCKS = BIT_CLOCKS_PADRAO,
    parameter int HALF_BIT   = HALF_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [6:0] dado,
    output logic       dado_valido,
    output logic       erro
);

    localparam int CW = $clog2(BIT_CLOCKS);
    localparam logic [CW-1:0] FIM_MEIO_BIT = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] FIM_BIT      = CW'(BIT_CLOCKS - 1);

    logic            sync1;
    logic            sync2;
    logic            anterior;
    logic [1:0]      enchimento;
    estado_char_t    estado;
    estado_char_t    proximo;
    logic [CW-1:0]   conta_baud;
    logic [2:0]      conta_bit;
    logic [7:0]      registro;
    logic            stop_bit;
    logic            borda_descida;
    logic            quadro_ok;
    logic            zera_contadores;
    logic            reinicia_baud;
    logic            amostra_dado;
    logic            amostra_stop;

    // Two-flop synchronizer. Its reset value of 1 is not a real observation
    // of the line, so 'enchimento' tracks when sync2 holds a genuine sample
    // and 'anterior' only remembers a high level that was really seen. This
    // keeps a line that is low when reset releases from looking like a start.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            enchimento <= 2'd0;
            anterior   <= 1'b0;
        end else begin
            sync1      <= entrada_serial;
            sync2      <= sync1;
            enchimento <= (enchimento == 2'd2) ? 2'd2 : enchimento + 2'd1;
            anterior   <= sync2 & (enchimento == 2'd2);
        end
    end

    assign borda_descida = anterior & ~sync2;

    // Character FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and control decode. The start bit is verified at its centre
    // and from there every sample is one full bit period later, so the data,
    // parity and stop bits are all taken near their centres.
    always_comb begin
        proximo         = estado;
        zera_contadores = 1'b0;
        reinicia_baud   = 1'b0;
        amostra_dado    = 1'b0;
        amostra_stop    = 1'b0;
        dado_valido     = 1'b0;
        erro            = 1'b0;
        case (estado)
            INICIAL: begin
                if (borda_descida) begin
                    zera_contadores = 1'b1;
                    proximo         = PREPARA;
                end
            end
            PREPARA: begin
                if (conta_baud == FIM_MEIO_BIT) begin
                    reinicia_baud = 1'b1;
                    proximo       = sync2 ? INICIAL : RECEBE;
                end
            end
            RECEBE: begin
                if (conta_baud == FIM_BIT) begin
                    reinicia_baud = 1'b1;
                    amostra_dado  = 1'b1;
                    if (conta_bit == 3'd7) begin
                        proximo = STOP;
                    end
                end
            end
            STOP: begin
                if (conta_baud == FIM_BIT) begin
                    amostra_stop = 1'b1;
                    proximo      = ENTREGA;
                end
            end
            ENTREGA: begin
                dado_valido = quadro_ok;
                erro        = ~quadro_ok;
                proximo     = INICIAL;
            end
            default: begin
                proximo = INICIAL;
            end
        endcase
    end

    // Baud and bit counters, both cleared when a start edge is accepted.
    always_ff @(posedge clock) begin
        if (reset || zera_contadores) begin
            conta_baud <= '0;
            conta_bit  <= 3'd0;
        end else begin
            conta_baud <= reinicia_baud ? '0 : conta_baud + CW'(1);
            if (amostra_dado) begin
                conta_bit <= conta_bit + 3'd1;
            end
        end
    end

    // Shift register fills from the top so that after eight samples bit 0
    // holds the first (least significant) data bit and bit 7 the parity.
    always_ff @(posedge clock) begin
        if (reset) begin
            registro <= 8'd0;
            stop_bit <= 1'b0;
        end else begin
            if (amostra_dado) begin
                registro <= {sync2, registro[7:1]};
            end
            if (amostra_stop) begin
                stop_bit <= sync2;
            end
        end
    end

    assign quadro_ok = (^registro) & stop_bit;
    assign dado      = registro[6:0];

endmodule

// File: rtl/rx_medida_serial.sv
// ---------------------------------------------------------------------------
// rx_medida_serial
// Receives "ddd#" frames from the trena transmitter and publishes the three
// ASCII digits as a 12-bit BCD measurement.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   entrada_serial in   raw RX line, idle high
//   medida         out  [11:0] last valid frame {d2,d1,d0}
//   pronto         out  1-cycle pulse when medida updates
//   erro_recepcao  out  1-cycle pulse on parity or stop-bit error
//   erro_formato   out  1-cycle pulse on a character out of place
//   db_estado      out  [3:0] frame-FSM state code
// ---------------------------------------------------------------------------
module rx_medida_serial
    import rx_medida_serial_pkg::*;
#(
    parameter int BIT_CLOCKS = BIT_CLOCKS_PADRAO,
    parameter int HALF_BIT   = HALF_BIT_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_recepcao,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    logic [6:0]     dado;
    logic           dado_valido;
    logic           erro_char;
    estado_quadro_t estado;
    estado_quadro_t proximo;
    logic [3:0]     d2;
    logic [3:0]     d1;
    logic [3:0]     d0;
    logic           carrega_d2;
    logic           carrega_d1;
    logic           carrega_d0;
    logic           publica;

    rx_serial_7O1 #(
        .BIT_CLOCKS (BIT_CLOCKS),
        .HALF_BIT   (HALF_BIT)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dado           (dado),
        .dado_valido    (dado_valido),
        .erro           (erro_char)
    );

    // Frame FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= ESPERA_D2;
        end else begin
            estado <= proximo;
        end
    end

    // Frame decode. A '#' while waiting for the first digit is treated as
    // the tail of an earlier frame and dropped quietly so the receiver can
    // resynchronise. A corrupted character always restarts the frame.
    always_comb begin
        proximo      = estado;
        pronto       = 1'b0;
        erro_formato = 1'b0;
        carrega_d2   = 1'b0;
        carrega_d1   = 1'b0;
        carrega_d0   = 1'b0;
        publica      = 1'b0;
        case (estado)
            ESPERA_D2: begin
                if (dado_valido) begin
                    if (eh_digito(dado)) begin
                        carrega_d2 = 1'b1;
                        proximo    = ESPERA_D1;
                    end else if (dado != ASCII_HASH) begin
                        erro_formato = 1'b1;
                    end
                end
            end
            ESPERA_D1: begin
                if (dado_valido) begin
                    if (eh_digito(dado)) begin
                        carrega_d1 = 1'b1;
                        proximo    = ESPERA_D0;
                    end else begin
                        erro_formato = 1'b1;
                        proximo      = ESPERA_D2;
                    end
                end
            end
            ESPERA_D0: begin
                if (dado_valido) begin
                    if (eh_digito(dado)) begin
                        carrega_d0 = 1'b1;
                        proximo    = ESPERA_HASH;
                    end else begin
                        erro_formato = 1'b1;
                        proximo      = ESPERA_D2;
                    end
                end
            end
            ESPERA_HASH: begin
                if (dado_valido) begin
                    if (dado == ASCII_HASH) begin
                        publica = 1'b1;
                        proximo = PUBLICA;
                    end else begin
                        erro_formato = 1'b1;
                        proximo      = ESPERA_D2;
                    end
                end
            end
            PUBLICA: begin
                pronto  = 1'b1;
                proximo = ESPERA_D2;
            end
            default: begin
                proximo = ESPERA_D2;
            end
        endcase
        if (erro_char) begin
            proximo = ESPERA_D2;
        end
    end

    // Digit registers and the published measurement. medida is loaded on
    // the same edge that enters PUBLICA, so it is already valid during the
    // cycle in which pronto is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            d2     <= 4'h0;
            d1     <= 4'h0;
            d0     <= 4'h0;
            medida <= 12'h000;
        end else begin
            if (carrega_d2) begin
                d2 <= dado[3:0];
            end
            if (carrega_d1) begin
                d1 <= dado[3:0];
            end
            if (carrega_d0) begin
                d0 <= dado[3:0];
            end
            if (publica) begin
                medida <= {d2, d1, d0};
            end
        end
    end

    assign erro_recepcao = erro_char;
    assign db_estado     = estado;

endmodule

// File: tb/tb_rx_medida_serial.sv
// ---------------------------------------------------------------------------
// tb_rx_medida_serial
// Drives 7O1 characters into rx_medida_serial and compares pulse counts,
// the published measurement and the frame state against a reference model
// that tracks the digits collected so far in a queue.
// ---------------------------------------------------------------------------
module tb_rx_medida_serial;

    localparam int BIT  = 40;
    localparam int MEIO = 20;

    logic        clock;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] medida;
    logic        pronto;
    logic        erro_recepcao;
    logic        erro_formato;
    logic [3:0]  db_estado;

    int vetores;
    int falhas;

    int n_pronto;
    int n_erro_rx;
    int n_erro_fmt;
    int coincidencias;
    logic [11:0] medida_no_pronto;

    int          esp_pronto;
    int          esp_erro_rx;
    int          esp_erro_fmt;
    logic [11:0] esp_medida;
    int          pendente[$];

    rx_medida_serial #(
        .BIT_CLOCKS (BIT),
        .HALF_BIT   (MEIO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .medida         (medida),
        .pronto         (pronto),
        .erro_recepcao  (erro_recepcao),
        .erro_formato   (erro_formato),
        .db_estado      (db_estado)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse monitor, sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (pronto) begin
                n_pronto++;
                medida_no_pronto = medida;
            end
            if (erro_recepcao) begin
                n_erro_rx++;
            end
            if (erro_formato) begin
                n_erro_fmt++;
            end
            if (pronto && (erro_recepcao || erro_formato)) begin
                coincidencias++;
            end
        end
    end

    // Reference model: digits accumulate in a queue; a complete frame is
    // three digits followed by '#'. A bad character empties the queue.
    task automatic referencia(input logic [6:0] c, input bit ok);
        bit digito;
        digito = (c >= 7'h30) && (c <= 7'h39);
        if (!ok) begin
            esp_erro_rx++;
            pendente.delete();
        end else if (pendente.size() < 3) begin
            if (digito) begin
                pendente.push_back(int'(c) - 48);
            end else if (c == 7'h23 && pendente.size() == 0) begin
                esp_erro_fmt = esp_erro_fmt;
            end else begin
                esp_erro_fmt++;
                pendente.delete();
            end
        end else begin
            if (c == 7'h23) begin
                esp_medida = 12'(pendente[0] * 256 + pendente[1] * 16 + pendente[2]);
                esp_pronto++;
            end else begin
                esp_erro_fmt++;
            end
            pendente.delete();
        end
    endtask

    // Sends one character: start, 7 data bits LSB first, parity, stop.
    task automatic applyStimulus(input logic [6:0] c, input bit par_errada, input bit stop_baixo);
        logic [9:0] quadro;
        logic       paridade;
        paridade = ~(^c) ^ par_errada;
        quadro   = {~stop_baixo, paridade, c, 1'b0};
        for (int i = 0; i < 10; i++) begin
            entrada_serial = quadro[i];
            repeat (BIT) @(negedge clock);
        end
        entrada_serial = 1'b1;
        referencia(c, !par_errada && !stop_baixo);
    endtask

    // Sends a string of characters back to back.
    task automatic envia_texto(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            applyStimulus(b[6:0], 1'b0, 1'b0);
        end
    endtask

    task automatic ocioso(input int ciclos);
        entrada_serial = 1'b1;
        repeat (ciclos) @(negedge clock);
    endtask

    task automatic checkOutput(input string nome, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        assert (obs === esp) else begin
            falhas++;
            $error("[TB] FAIL %s: observed %0h expected %0h", nome, obs, esp);
        end
    endtask

    task automatic verifica_tudo(input string tag);
        ocioso(5);
        checkOutput({tag, " pronto_count"}, n_pronto, esp_pronto);
        checkOutput({tag, " erro_rx_count"}, n_erro_rx, esp_erro_rx);
        checkOutput({tag, " erro_fmt_count"}, n_erro_fmt, esp_erro_fmt);
        checkOutput({tag, " medida"}, 32'(medida), 32'(esp_medida));
        checkOutput({tag, " db_estado"}, 32'(db_estado), pendente.size());
        checkOutput({tag, " pulse_overlap"}, coincidencias, 0);
    endtask

    // Directed scenarios followed by randomised frames.
    initial begin
        logic [6:0] c;
        bit         pe;
        bit         sb;
        int         sorte;

        vetores          = 0;
        falhas           = 0;
        n_pronto         = 0;
        n_erro_rx        = 0;
        n_erro_fmt       = 0;
        coincidencias    = 0;
        medida_no_pronto = 12'h000;
        esp_pronto       = 0;
        esp_erro_rx      = 0;
        esp_erro_fmt     = 0;
        esp_medida       = 12'h000;
        reset            = 1'b1;
        entrada_serial   = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        ocioso(3);
        checkOutput("reset pronto", 32'(pronto), 0);
        checkOutput("reset erro_recepcao", 32'(erro_recepcao), 0);
        checkOutput("reset erro_formato", 32'(erro_formato), 0);
        verifica_tudo("reset");

        $display("[TB] complete frame 123#");
        envia_texto("123#");
        verifica_tudo("frame123");
        checkOutput("frame123 medida_at_pronto", 32'(medida_no_pronto), 32'h123);

        $display("[TB] parity error inside frame");
        applyStimulus(7'h31, 1'b0, 1'b0);
        applyStimulus(7'h32, 1'b1, 1'b0);
        envia_texto("45#");
        verifica_tudo("parity");
        envia_texto("045#");
        verifica_tudo("frame045");

        $display("[TB] format error and resync");
        envia_texto("1A3#");
        verifica_tudo("format");
        envia_texto("#");
        verifica_tudo("resync_hash");
        envia_texto("907#");
        verifica_tudo("frame907");

        $display("[TB] short glitch on the line");
        entrada_serial = 1'b0;
        repeat (MEIO / 2) @(negedge clock);
        ocioso(BIT * 5);
        verifica_tudo("glitch");

        $display("[TB] reset in the middle of a character");
        envia_texto("12");
        entrada_serial = 1'b0;
        repeat (MEIO) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset          = 1'b0;
        entrada_serial = 1'b1;
        pendente.delete();
        esp_medida = 12'h000;
        ocioso(BIT * 2);
        verifica_tudo("mid_reset");
        envia_texto("789#");
        verifica_tudo("frame789");

        $display("[TB] back-to-back frames, last stop bit low");
        envia_texto("999#000");
        applyStimulus(7'h23, 1'b0, 1'b1);
        ocioso(BIT);
        verifica_tudo("back_to_back");

        $display("[TB] randomised frames");
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                c     = (k == 3) ? 7'h23 : 7'(7'h30 + $urandom_range(0, 9));
                sorte = $urandom_range(0, 11);
                pe    = 1'b0;
                sb    = 1'b0;
                if (sorte == 0) begin
                    pe = 1'b1;
                end else if (sorte == 1) begin
                    c = 7'($urandom_range(65, 90));
                end else if (sorte == 2) begin
                    sb = 1'b1;
                end else if (sorte == 3) begin
                    c = 7'h23;
                end
                applyStimulus(c, pe, sb);
                if (sb) begin
                    ocioso(BIT);
                end else begin
                    ocioso($urandom_range(0, 3) * 10);
                end
            end
            verifica_tudo("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vetores, falhas);
        $finish;
    end

endmodule
